// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the memory arbiter slice.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        G_I,
        G_D
    } grant_t;

    localparam int DEFAULT_WIDTH        = 32;
    localparam int DEFAULT_STARVE_LIMIT = 4;
    localparam int DEFAULT_TIMEOUT      = 16;

endpackage

// File: rtl/arb_watchdog.sv
// Loadable down-counter that flags an access which never receives MemAck.
// Loaded on start, cleared by ack; expired is high on the last cycle of the budget.
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic CLK,
    input  logic RST,
    input  logic start,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Load the full budget on start, drop to zero on ack, otherwise count down and stop at zero
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (start) begin
            count <= CW'(TIMEOUT);
        end else if (ack) begin
            count <= '0;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expired = (count == CW'(1));

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port, Ack-based memory between the fetch port (I) and the
// load/store port (D). One access in flight; D has priority, but I is forced
// through after STARVE_LIMIT back-to-back D grants while it waits.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IReadEnable,
    input  logic [31:0]      IAddress,
    output logic             IAck,
    output logic [WIDTH-1:0] IInstr,
    input  logic             DReadEnable,
    input  logic             DWriteEnable,
    input  logic [31:0]      DAddress,
    input  logic [WIDTH-1:0] DWriteData,
    output logic             DAck,
    output logic [WIDTH-1:0] DReadData,
    output logic             MemReadEnable,
    output logic             MemWriteEnable,
    output logic [31:0]      MemAddress,
    output logic [WIDTH-1:0] MemWriteData,
    input  logic             MemAck,
    input  logic [WIDTH-1:0] MemReadData,
    output logic             MemErr
);

    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    arb_state_t     state;
    grant_t         grant;
    logic           is_write;
    logic [SCW-1:0] starve_cnt;
    logic           d_req;
    logic           i_forced;
    logic           grant_d;
    logic           grant_i;
    logic           wd_start;
    logic           wd_ack;
    logic           wd_expired;

    assign d_req    = DReadEnable | DWriteEnable;
    assign i_forced = IReadEnable && (starve_cnt == SCW'(STARVE_LIMIT));
    assign grant_d  = d_req && !i_forced;
    assign grant_i  = IReadEnable && !grant_d;

    assign wd_start = (state == ISSUE);
    assign wd_ack   = MemAck && (state == WAIT);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK     (CLK),
        .RST     (RST),
        .start   (wd_start),
        .ack     (wd_ack),
        .expired (wd_expired)
    );

    // Access sequencer: arbitrate in IDLE, pulse the enable in ISSUE, wait for Ack or timeout, acknowledge in DONE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            grant          <= G_I;
            is_write       <= 1'b0;
            IAck           <= 1'b0;
            DAck           <= 1'b0;
            IInstr         <= '0;
            DReadData      <= '0;
            MemReadEnable  <= 1'b0;
            MemWriteEnable <= 1'b0;
            MemAddress     <= '0;
            MemWriteData   <= '0;
            MemErr         <= 1'b0;
        end else begin
            IAck           <= 1'b0;
            DAck           <= 1'b0;
            MemReadEnable  <= 1'b0;
            MemWriteEnable <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        grant          <= G_D;
                        is_write       <= DWriteEnable;
                        MemAddress     <= DAddress;
                        MemWriteData   <= DWriteData;
                        MemWriteEnable <= DWriteEnable;
                        MemReadEnable  <= !DWriteEnable;
                        state          <= ISSUE;
                    end else if (grant_i) begin
                        grant          <= G_I;
                        is_write       <= 1'b0;
                        MemAddress     <= IAddress;
                        MemWriteData   <= '0;
                        MemReadEnable  <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (MemAck) begin
                        if (grant == G_I) begin
                            IInstr <= MemReadData;
                            IAck   <= 1'b1;
                        end else begin
                            if (!is_write) begin
                                DReadData <= MemReadData;
                            end
                            DAck <= 1'b1;
                        end
                        state <= DONE;
                    end else if (wd_expired) begin
                        MemErr <= 1'b1;
                        if (grant == G_I) begin
                            IInstr <= '0;
                            IAck   <= 1'b1;
                        end else begin
                            if (!is_write) begin
                                DReadData <= '0;
                            end
                            DAck <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Track consecutive D grants that bypassed a waiting fetch, saturating at the limit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                if (IReadEnable) begin
                    if (starve_cnt != SCW'(STARVE_LIMIT)) begin
                        starve_cnt <= starve_cnt + SCW'(1);
                    end
                end else begin
                    starve_cnt <= '0;
                end
            end else if (grant_i) begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a behavioural memory with programmable
// Ack delay, a table of single accesses, hand-written multi-cycle sequences and a
// randomized two-requester run checked against a shadow-memory reference model.
module tb_memory_arbiter;

    localparam int WIDTH        = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 16;

    logic        CLK;
    logic        RST;
    logic        IReadEnable;
    logic [31:0] IAddress;
    logic        IAck;
    logic [31:0] IInstr;
    logic        DReadEnable;
    logic        DWriteEnable;
    logic [31:0] DAddress;
    logic [31:0] DWriteData;
    logic        DAck;
    logic [31:0] DReadData;
    logic        MemReadEnable;
    logic        MemWriteEnable;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemAck;
    logic [31:0] MemReadData;
    logic        MemErr;

    int checks   = 0;
    int failures = 0;

    memory_arbiter #(
        .WIDTH        (WIDTH),
        .STARVE_LIMIT (STARVE_LIMIT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .IReadEnable    (IReadEnable),
        .IAddress       (IAddress),
        .IAck           (IAck),
        .IInstr         (IInstr),
        .DReadEnable    (DReadEnable),
        .DWriteEnable   (DWriteEnable),
        .DAddress       (DAddress),
        .DWriteData     (DWriteData),
        .DAck           (DAck),
        .DReadData      (DReadData),
        .MemReadEnable  (MemReadEnable),
        .MemWriteEnable (MemWriteEnable),
        .MemAddress     (MemAddress),
        .MemWriteData   (MemWriteData),
        .MemAck         (MemAck),
        .MemReadData    (MemReadData),
        .MemErr         (MemErr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural memory: 16 words, Ack arrives effDelay cycles after the enable pulse
    logic [31:0] ram [16];
    logic [31:0] shadow [16];
    logic        modelAck;
    logic        strayAck;
    logic        noAck;
    logic        randDelay;
    int          ackDelay;
    int          randDly;
    int          effDelay;
    logic        memBusy;
    int          memCnt;
    logic        memWr;
    logic [3:0]  memIdx;
    logic [31:0] memWdata;

    assign MemAck = modelAck | strayAck;

    always_comb effDelay = randDelay ? randDly : ackDelay;

    always @(negedge CLK) randDly <= int'($urandom_range(3, 1));

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            modelAck    <= 1'b0;
            memBusy     <= 1'b0;
            memCnt      <= 0;
            memWr       <= 1'b0;
            memIdx      <= 4'd0;
            memWdata    <= 32'd0;
            MemReadData <= 32'd0;
            for (int i = 0; i < 16; i++) ram[i] <= 32'h1000_0000 + 32'(i);
            ram[2] <= 32'hDEAD_BEEF;
        end else begin
            modelAck <= 1'b0;
            if (MemReadEnable || MemWriteEnable) begin
                if (effDelay <= 1) begin
                    memBusy <= 1'b0;
                    if (!noAck) begin
                        modelAck <= 1'b1;
                        if (MemWriteEnable) ram[MemAddress[5:2]] <= MemWriteData;
                        else MemReadData <= ram[MemAddress[5:2]];
                    end
                end else begin
                    memBusy  <= 1'b1;
                    memCnt   <= effDelay - 1;
                    memWr    <= MemWriteEnable;
                    memIdx   <= MemAddress[5:2];
                    memWdata <= MemWriteData;
                end
            end else if (memBusy) begin
                if (memCnt <= 1) begin
                    memBusy <= 1'b0;
                    if (!noAck) begin
                        modelAck <= 1'b1;
                        if (memWr) ram[memIdx] <= memWdata;
                        else MemReadData <= ram[memIdx];
                    end
                end else begin
                    memCnt <= memCnt - 1;
                end
            end
        end
    end

    typedef struct {
        logic        isD;
        logic        isWrite;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One isolated access from an idle arbiter; reports latency (in cycles from the request), data and pulse counts
    task automatic applyStimulus(input vec_t v, output int lat, output logic [31:0] rdata,
                                 output int enPulses, output int otherPulses, output logic [31:0] addrAtAck);
        @(negedge CLK);
        ackDelay = v.delay;
        if (v.isD) begin
            DAddress     = v.addr;
            DWriteData   = v.wdata;
            DReadEnable  = !v.isWrite;
            DWriteEnable = v.isWrite;
        end else begin
            IAddress    = v.addr;
            IReadEnable = 1'b1;
        end
        lat = -1; enPulses = 0; otherPulses = 0; rdata = 32'd0; addrAtAck = 32'd0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge CLK);
            if (v.isWrite ? MemWriteEnable : MemReadEnable) enPulses++;
            if (v.isWrite ? MemReadEnable : MemWriteEnable) otherPulses++;
            if ((v.isD && DAck) || (!v.isD && IAck)) begin
                lat       = k;
                rdata     = v.isD ? DReadData : IInstr;
                addrAtAck = MemAddress;
            end
        end
        DReadEnable  = 1'b0;
        DWriteEnable = 1'b0;
        IReadEnable  = 1'b0;
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int lat; int en; int other; logic [31:0] rd; logic [31:0] addrAck;
        applyStimulus(v, lat, rd, en, other, addrAck);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(2 + v.delay));
        checkOutput({tag, "_enable_pulses"}, 32'(en), 32'd1);
        checkOutput({tag, "_wrong_enable"}, 32'(other), 32'd0);
        checkOutput({tag, "_mem_address"}, addrAck, v.addr);
        if (!v.isWrite) checkOutput({tag, "_data"}, rd, v.expData);
    endtask

    initial begin
        int dAckAt; int iAckAt; int dCount; int iSeen; int cnts [2]; int spurious;
        int lat; logic [31:0] rd; logic errBefore;
        logic iPend; logic dPend; logic dWr; logic [3:0] iIdx; logic [3:0] dIdx; logic [31:0] dData;
        int iWait; int dWait; int dDuringI; int iAcks; int dAcks;

        RST = 1'b0; IReadEnable = 1'b0; IAddress = 32'd0; DReadEnable = 1'b0; DWriteEnable = 1'b0;
        DAddress = 32'd0; DWriteData = 32'd0; strayAck = 1'b0; noAck = 1'b0; randDelay = 1'b0; ackDelay = 1;

        vecs[0] = '{isD: 1'b1, isWrite: 1'b1, addr: 32'h10, wdata: 32'h1234_5678, delay: 1, expData: 32'h0};
        vecs[1] = '{isD: 1'b1, isWrite: 1'b0, addr: 32'h10, wdata: 32'h0,         delay: 1, expData: 32'h1234_5678};
        vecs[2] = '{isD: 1'b0, isWrite: 1'b0, addr: 32'h08, wdata: 32'h0,         delay: 1, expData: 32'hDEAD_BEEF};
        vecs[3] = '{isD: 1'b1, isWrite: 1'b0, addr: 32'h08, wdata: 32'h0,         delay: 3, expData: 32'hDEAD_BEEF};
        vecs[4] = '{isD: 1'b0, isWrite: 1'b0, addr: 32'h10, wdata: 32'h0,         delay: 2, expData: 32'h1234_5678};
        vecs[5] = '{isD: 1'b1, isWrite: 1'b1, addr: 32'h3C, wdata: 32'hA5A5_0F0F, delay: 2, expData: 32'h0};
        vecs[6] = '{isD: 1'b0, isWrite: 1'b0, addr: 32'h3C, wdata: 32'h0,         delay: 1, expData: 32'hA5A5_0F0F};
        vecs[7] = '{isD: 1'b1, isWrite: 1'b0, addr: 32'h20, wdata: 32'h0,         delay: 1, expData: 32'h1000_0008};

        // Reset state
        #1 RST = 1'b1;
        @(negedge CLK); @(negedge CLK);
        checkOutput("reset_iack", 32'(IAck), 32'd0);
        checkOutput("reset_dack", 32'(DAck), 32'd0);
        checkOutput("reset_mem_re", 32'(MemReadEnable), 32'd0);
        checkOutput("reset_mem_we", 32'(MemWriteEnable), 32'd0);
        checkOutput("reset_memerr", 32'(MemErr), 32'd0);
        checkOutput("reset_mem_addr", MemAddress, 32'd0);
        checkOutput("reset_mem_wdata", MemWriteData, 32'd0);
        checkOutput("reset_iinstr", IInstr, 32'd0);
        checkOutput("reset_dreaddata", DReadData, 32'd0);
        RST = 1'b0;

        // Single accesses from the table
        for (int i = 0; i < 8; i++) runVector(vecs[i], $sformatf("vec%0d", i));

        // Stray MemAck while idle must not produce any requester Ack
        @(negedge CLK);
        strayAck = 1'b1;
        @(negedge CLK);
        strayAck = 1'b0;
        spurious = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (IAck || DAck || MemReadEnable || MemWriteEnable) spurious++;
        end
        checkOutput("stray_ack_ignored", 32'(spurious), 32'd0);
        checkOutput("stray_memerr", 32'(MemErr), 32'd0);

        // D and I together: D first, then I right after D's DONE
        @(negedge CLK);
        DAddress = 32'h10; DReadEnable = 1'b1; IAddress = 32'h08; IReadEnable = 1'b1;
        dAckAt = -1; iAckAt = -1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge CLK);
            if (DAck && dAckAt < 0) begin dAckAt = k; DReadEnable = 1'b0; checkOutput("both_ddata", DReadData, 32'h1234_5678); end
            if (IAck && iAckAt < 0) begin iAckAt = k; IReadEnable = 1'b0; checkOutput("both_idata", IInstr, 32'hDEAD_BEEF); end
        end
        DReadEnable = 1'b0; IReadEnable = 1'b0;
        checkOutput("both_dack_cycle", 32'(dAckAt), 32'd3);
        checkOutput("both_iack_cycle", 32'(iAckAt), 32'd7);

        // Starvation: D held continuously with I pending gives STARVE_LIMIT DAcks per IAck, twice
        @(negedge CLK);
        DAddress = 32'h04; DReadEnable = 1'b1; IAddress = 32'h08; IReadEnable = 1'b1;
        dCount = 0; iSeen = 0; cnts[0] = -1; cnts[1] = -1;
        for (int k = 0; k < 100 && iSeen < 2; k++) begin
            @(negedge CLK);
            if (DAck) dCount++;
            if (IAck) begin cnts[iSeen] = dCount; dCount = 0; iSeen++; end
        end
        DReadEnable = 1'b0; IReadEnable = 1'b0;
        checkOutput("starve_first_dacks", 32'(cnts[0]), 32'(STARVE_LIMIT));
        checkOutput("starve_second_dacks", 32'(cnts[1]), 32'(STARVE_LIMIT));

        // Reset in WAIT: outputs clear at once and the aborted access never acknowledges
        @(negedge CLK); @(negedge CLK);
        ackDelay = 3; IAddress = 32'h08; IReadEnable = 1'b1;
        @(negedge CLK);
        checkOutput("midreset_issue_re", 32'(MemReadEnable), 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checkOutput("midreset_iack", 32'(IAck), 32'd0);
        checkOutput("midreset_mem_re", 32'(MemReadEnable), 32'd0);
        checkOutput("midreset_mem_addr", MemAddress, 32'd0);
        checkOutput("midreset_iinstr", IInstr, 32'd0);
        IReadEnable = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        spurious = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (IAck || DAck || MemReadEnable || MemWriteEnable) spurious++;
        end
        checkOutput("midreset_no_ack", 32'(spurious), 32'd0);
        runVector(vecs[2], "postreset");

        // Memory never answers: watchdog ends the access with data 0 and sets sticky MemErr
        noAck = 1'b1; ackDelay = 1;
        @(negedge CLK);
        DAddress = 32'h10; DReadEnable = 1'b1;
        lat = -1; rd = 32'hFFFF_FFFF; errBefore = 1'b1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge CLK);
            if (k == 1 + TIMEOUT) errBefore = MemErr;
            if (DAck) begin lat = k; rd = DReadData; end
        end
        DReadEnable = 1'b0;
        noAck = 1'b0;
        checkOutput("timeout_latency", 32'(lat), 32'(2 + TIMEOUT));
        checkOutput("timeout_data", rd, 32'd0);
        checkOutput("timeout_memerr", 32'(MemErr), 32'd1);
        checkOutput("timeout_memerr_before", 32'(errBefore), 32'd0);

        // Randomized requesters against a shadow-memory model
        @(negedge CLK); @(negedge CLK);
        shadow = ram;
        randDelay = 1'b1;
        iPend = 1'b0; dPend = 1'b0; dWr = 1'b0; iIdx = 4'd0; dIdx = 4'd0; dData = 32'd0;
        iWait = 0; dWait = 0; dDuringI = 0; iAcks = 0; dAcks = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge CLK);
            if (IAck) begin
                checkOutput("rand_i_pending", 32'(iPend), 32'd1);
                checkOutput("rand_iinstr", IInstr, shadow[iIdx]);
                checkOutput("rand_i_starve_bound", 32'(dDuringI <= STARVE_LIMIT + 1), 32'd1);
                iPend = 1'b0; IReadEnable = 1'b0; iAcks++;
            end
            if (DAck) begin
                checkOutput("rand_d_pending", 32'(dPend), 32'd1);
                if (dWr) shadow[dIdx] = dData;
                else checkOutput("rand_dreaddata", DReadData, shadow[dIdx]);
                dPend = 1'b0; DReadEnable = 1'b0; DWriteEnable = 1'b0; dAcks++;
                if (iPend) dDuringI++;
            end
            if (cyc < 2900 && !iPend && !IAck && $urandom_range(3, 0) == 0) begin
                iIdx = 4'($urandom_range(15, 0));
                IAddress = {26'd0, iIdx, 2'b00};
                IReadEnable = 1'b1; iPend = 1'b1; iWait = 0; dDuringI = 0;
            end
            if (cyc < 2900 && !dPend && !DAck && $urandom_range(2, 0) == 0) begin
                dIdx = 4'($urandom_range(15, 0));
                dWr = 1'($urandom_range(1, 0));
                dData = $urandom;
                DAddress = {26'd0, dIdx, 2'b00};
                DWriteData = dData;
                DReadEnable = !dWr; DWriteEnable = dWr; dPend = 1'b1; dWait = 0;
            end
            if (iPend) iWait++;
            if (dPend) dWait++;
            if (iWait > 200) begin checkOutput("rand_i_wait", 32'(iWait), 32'd200); iWait = 0; end
            if (dWait > 200) begin checkOutput("rand_d_wait", 32'(dWait), 32'd200); dWait = 0; end
        end
        checkOutput("rand_drained", 32'(iPend | dPend), 32'd0);
        checkOutput("rand_activity", 32'(iAcks > 20 && dAcks > 20), 32'd1);
        checkOutput("memerr_sticky", 32'(MemErr), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
